// File: rtl/atmega_pll_ctrl.sv
// ATmega PLL control: PLLCSR/PLLFRQ registers, emulated lock timer and sequenced clock-source switching.
// Optional lock interrupt is built when ATMEGA_PLL_CTRL_LOCK_IRQ_EN is defined.
module atmega_pll_ctrl #(
    parameter int                           BUS_ADDR_DATA_LEN = 16,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] PLLCSR_ADDR       = 'h49,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] PLLFRQ_ADDR       = 'h52,
    parameter int                           LOCK_CYCLES       = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
    input  logic                         wr_i,
    input  logic                         rd_i,
    input  logic [7:0]                   bus_i,
    output logic [7:0]                   bus_o,
    output logic                         pll_en_o,
    output logic [3:0]                   pll_pdiv_o,
    output logic [1:0]                   pll_tim_o,
    output logic                         pll_usb_o,
    output logic                         lock_o,
    output logic                         busy_o,
    output logic                         irq_o,
    input  logic                         irq_ack_i
);
    typedef enum logic [1:0] {OFF, LOCKING, LOCKED, GAP} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       gap_q, gap_d;
    logic [7:0] frq_q, frq_d;
    logic       pindiv_q, pindiv_d;
    logic       plle_q, plle_d;
    logic       lock_d, usb_d, en_d, busy_d;
    logic [3:0] pdiv_d;
    logic [1:0] tim_d;
    logic       wr_csr, wr_frq, relock, tm_change;

    function automatic logic pdiv_valid(input logic [3:0] p);
        case (p)
            4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10: pdiv_valid = 1'b1;
            default:                                   pdiv_valid = 1'b0;
        endcase
    endfunction

    assign wr_csr = wr_i && (addr_i == PLLCSR_ADDR);
    assign wr_frq = wr_i && (addr_i == PLLFRQ_ADDR);
    // A new valid divider while the PLL runs forces a full relock.
    assign relock    = wr_frq && (state_q != OFF) && pdiv_valid(bus_i[3:0])
                       && (bus_i[3:0] != pll_pdiv_o);
    assign tm_change = wr_frq && ((state_q == LOCKED) || (state_q == GAP))
                       && (bus_i[5:4] != frq_q[5:4]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        frq_d    = frq_q;
        pindiv_d = pindiv_q;
        plle_d   = plle_q;
        lock_d   = lock_o;
        pdiv_d   = pll_pdiv_o;
        usb_d    = pll_usb_o;
        if (wr_csr) begin
            pindiv_d = bus_i[4];
            plle_d   = bus_i[1];
        end
        if (wr_frq) begin
            frq_d = bus_i;
            usb_d = bus_i[6];
        end
        case (state_q)
            OFF: begin
                if (wr_csr && bus_i[1]) begin
                    state_d = LOCKING;
                    cnt_d   = 8'(LOCK_CYCLES - 1);
                    if (pdiv_valid(frq_q[3:0])) pdiv_d = frq_q[3:0];
                end
            end
            LOCKING: begin
                if (cnt_q == 8'd0) begin
                    state_d = LOCKED;
                    lock_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GAP: begin
                if (gap_q) gap_d = 1'b0;
                else       state_d = LOCKED;
            end
            default: ;
        endcase
        if (relock) begin
            state_d = LOCKING;
            cnt_d   = 8'(LOCK_CYCLES - 1);
            pdiv_d  = bus_i[3:0];
            lock_d  = 1'b0;
        end else if (tm_change) begin
            // Two system-clock cycles with the timer on clk_i before the new source.
            state_d = GAP;
            gap_d   = 1'b1;
        end
        if (wr_csr && !bus_i[1]) begin
            state_d = OFF;
            cnt_d   = 8'd0;
            gap_d   = 1'b0;
            lock_d  = 1'b0;
        end
        en_d   = (state_d != OFF);
        busy_d = (state_d == LOCKING) || (state_d == GAP);
        tim_d  = (state_d == LOCKED) ? frq_d[5:4] : 2'b00;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= OFF;
            cnt_q      <= 8'd0;
            gap_q      <= 1'b0;
            frq_q      <= 8'h04;
            pindiv_q   <= 1'b0;
            plle_q     <= 1'b0;
            lock_o     <= 1'b0;
            pll_pdiv_o <= 4'b0100;
            pll_usb_o  <= 1'b0;
            pll_en_o   <= 1'b0;
            busy_o     <= 1'b0;
            pll_tim_o  <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            frq_q      <= frq_d;
            pindiv_q   <= pindiv_d;
            plle_q     <= plle_d;
            lock_o     <= lock_d;
            pll_pdiv_o <= pdiv_d;
            pll_usb_o  <= usb_d;
            pll_en_o   <= en_d;
            busy_o     <= busy_d;
            pll_tim_o  <= tim_d;
        end
    end

    always_comb begin
        bus_o = 8'h00;
        if (rd_i) begin
            if (addr_i == PLLCSR_ADDR)      bus_o = {3'b000, pindiv_q, 2'b00, plle_q, lock_o};
            else if (addr_i == PLLFRQ_ADDR) bus_o = frq_q;
        end
    end

`ifdef ATMEGA_PLL_CTRL_LOCK_IRQ_EN
    logic lock_evt;
    assign lock_evt = (state_q == LOCKING) && (state_d == LOCKED);

    // Set wins over a simultaneous acknowledge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)       irq_o <= 1'b0;
        else if (lock_evt)  irq_o <= 1'b1;
        else if (irq_ack_i) irq_o <= 1'b0;
    end
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack_i;
    assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_atmega_pll_ctrl.sv
// Bench for atmega_pll_ctrl: vector table, directed corner sequences, and random traffic vs. a time-based model.
module tb_atmega_pll_ctrl;
    localparam int          LC  = 16;
    localparam logic [15:0] CSR = 16'h0049;
    localparam logic [15:0] FRQ = 16'h0052;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [15:0] addr_i = '0;
    logic        wr_i = 1'b0, rd_i = 1'b0, irq_ack_i = 1'b0;
    logic [7:0]  bus_i = '0;
    logic [7:0]  bus_o;
    logic        pll_en_o, pll_usb_o, lock_o, busy_o, irq_o;
    logic [3:0]  pll_pdiv_o;
    logic [1:0]  pll_tim_o;

    atmega_pll_ctrl dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .addr_i(addr_i), .wr_i(wr_i), .rd_i(rd_i),
        .bus_i(bus_i), .bus_o(bus_o), .pll_en_o(pll_en_o), .pll_pdiv_o(pll_pdiv_o),
        .pll_tim_o(pll_tim_o), .pll_usb_o(pll_usb_o), .lock_o(lock_o), .busy_o(busy_o),
        .irq_o(irq_o), .irq_ack_i(irq_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled there too.
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr_i = a; bus_i = d; wr_i = 1'b1;
        @(posedge clk_i); #1;
        wr_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        addr_i = a; rd_i = 1'b1;
        #1 d = bus_o;
        rd_i = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        int          idle;
        logic        en;
        logic        lock;
        logic [1:0]  tim;
        logic [3:0]  pdiv;
        logic        busy;
        logic [7:0]  csr;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t mk(logic w, logic [15:0] a, logic [7:0] d, int n,
                                logic en, logic lk, logic [1:0] tm, logic [3:0] pd,
                                logic bz, logic [7:0] cs);
        vec_t v;
        v.wr = w; v.addr = a; v.data = d; v.idle = n;
        v.en = en; v.lock = lk; v.tim = tm; v.pdiv = pd; v.busy = bz; v.csr = cs;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // Lock and gap are tracked as absolute edge times rather than as a state machine.
    bit         m_en, m_usb, m_pindiv, m_plle, m_irq;
    int         m_lock_t, m_gap_end, m_now;
    logic [3:0] m_pdiv;
    logic [7:0] m_frq;

    function automatic bit m_locked(int now);
        return m_en && (now >= m_lock_t);
    endfunction

    function automatic bit m_pdiv_ok(logic [3:0] p);
        return p inside {4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10};
    endfunction

    function automatic logic [7:0] m_read(logic [15:0] a);
        if (a == CSR) return {3'b000, m_pindiv, 2'b00, m_plle, m_locked(m_now)};
        if (a == FRQ) return m_frq;
        return 8'h00;
    endfunction

    function automatic logic [10:0] m_outs();
        logic [1:0] tm;
        bit bz, iq;
        tm = (m_locked(m_now) && m_now >= m_gap_end) ? m_frq[5:4] : 2'b00;
        bz = m_en && (!m_locked(m_now) || m_now < m_gap_end);
`ifdef ATMEGA_PLL_CTRL_LOCK_IRQ_EN
        iq = m_irq;
`else
        iq = 1'b0;
`endif
        return {m_en, m_pdiv, tm, m_usb, m_locked(m_now), bz, iq};
    endfunction

    task automatic m_reset();
        m_en = 0; m_usb = 0; m_pindiv = 0; m_plle = 0; m_irq = 0;
        m_lock_t = 0; m_gap_end = 0; m_now = 0; m_pdiv = 4'd4; m_frq = 8'h04;
    endtask

    task automatic m_edge(bit w, logic [15:0] a, logic [7:0] d, bit ack);
        int t;
        bit prev;
        t = m_now + 1;
        prev = m_locked(m_now);
        if (w && a == CSR) begin
            m_pindiv = d[4]; m_plle = d[1];
            if (!d[1]) m_en = 0;
            else if (!m_en) begin
                m_en = 1; m_lock_t = t + LC; m_gap_end = 0;
                if (m_pdiv_ok(m_frq[3:0])) m_pdiv = m_frq[3:0];
            end
        end
        if (w && a == FRQ) begin
            m_usb = d[6];
            if (m_en) begin
                if (m_pdiv_ok(d[3:0]) && d[3:0] != m_pdiv) begin
                    m_pdiv = d[3:0]; m_lock_t = t + LC; m_gap_end = 0;
                end else if (prev && d[5:4] != m_frq[5:4]) begin
                    m_gap_end = t + 2;
                end
            end
            m_frq = d;
        end
        if (!prev && m_locked(t)) m_irq = 1;
        else if (ack)             m_irq = 0;
        m_now = t;
    endtask

    logic [7:0]  rdv;
    logic [15:0] ra;
    logic [7:0]  rdat;
    bit          rw;
    bit          exp_irq;

    initial begin
`ifdef ATMEGA_PLL_CTRL_LOCK_IRQ_EN
        exp_irq = 1'b1;
`else
        exp_irq = 1'b0;
`endif
        // reset state
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        idle(1);
        rd(CSR, rdv); chk("reset_csr", rdv, 8'h00);
        rd(FRQ, rdv); chk("reset_frq", rdv, 8'h04);
        chk("reset_outs", {pll_en_o, pll_pdiv_o, pll_tim_o, pll_usb_o, lock_o, busy_o, irq_o},
            {1'b0, 4'd4, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});

        // lock, relock on PDIV change, invalid PDIV, and timer-source gap
        vt.push_back(mk(1, FRQ, 8'h1A, 0, 0, 0, 2'b00, 4'd4,  0, 8'h00));
        vt.push_back(mk(1, CSR, 8'h02, 0, 1, 0, 2'b00, 4'd10, 1, 8'h02));
        vt.push_back(mk(0, CSR, 8'h00, 14, 1, 0, 2'b00, 4'd10, 1, 8'h02));
        vt.push_back(mk(0, CSR, 8'h00, 1, 1, 0, 2'b00, 4'd10, 1, 8'h02));
        vt.push_back(mk(0, CSR, 8'h00, 1, 1, 1, 2'b01, 4'd10, 0, 8'h03));
        vt.push_back(mk(1, FRQ, 8'h13, 0, 1, 0, 2'b00, 4'd3,  1, 8'h02));
        vt.push_back(mk(0, CSR, 8'h00, 15, 1, 0, 2'b00, 4'd3,  1, 8'h02));
        vt.push_back(mk(0, CSR, 8'h00, 1, 1, 1, 2'b01, 4'd3,  0, 8'h03));
        vt.push_back(mk(1, FRQ, 8'h06, 0, 1, 1, 2'b00, 4'd3,  1, 8'h03));
        vt.push_back(mk(0, CSR, 8'h00, 2, 1, 1, 2'b00, 4'd3,  0, 8'h03));
        vt.push_back(mk(1, FRQ, 8'h14, 0, 1, 0, 2'b00, 4'd4,  1, 8'h02));
        vt.push_back(mk(0, CSR, 8'h00, 16, 1, 1, 2'b01, 4'd4,  0, 8'h03));
        vt.push_back(mk(1, FRQ, 8'h34, 0, 1, 1, 2'b00, 4'd4,  1, 8'h03));
        vt.push_back(mk(0, CSR, 8'h00, 1, 1, 1, 2'b00, 4'd4,  1, 8'h03));
        vt.push_back(mk(0, CSR, 8'h00, 1, 1, 1, 2'b11, 4'd4,  0, 8'h03));
        foreach (vt[i]) begin
            if (vt[i].wr) wr(vt[i].addr, vt[i].data);
            else          idle(vt[i].idle);
            chk($sformatf("vec%0d_outs", i), {pll_en_o, lock_o, pll_tim_o, pll_pdiv_o, busy_o},
                {vt[i].en, vt[i].lock, vt[i].tim, vt[i].pdiv, vt[i].busy});
            rd(CSR, rdv);
            chk($sformatf("vec%0d_csr", i), rdv, vt[i].csr);
        end

        // disable from LOCKED, then abort LOCKING at counter=5
        wr(CSR, 8'h00);
        chk("off_outs", {pll_en_o, lock_o, pll_tim_o, busy_o, pll_pdiv_o}, {1'b0, 1'b0, 2'b00, 1'b0, 4'd4});
        wr(CSR, 8'h02);
        idle(10);
        wr(CSR, 8'h00);
        chk("abort_outs", {pll_en_o, lock_o, busy_o}, 3'b000);
        rd(CSR, rdv); chk("abort_csr", rdv, 8'h00);
        idle(12);
        chk("abort_stays_off", {pll_en_o, lock_o}, 2'b00);

        // asynchronous reset mid-LOCKING
        wr(FRQ, 8'h5A);
        wr(CSR, 8'h02);
        idle(3);
        chk("pre_rst", {pll_en_o, pll_pdiv_o, pll_usb_o, busy_o}, {1'b1, 4'd10, 1'b1, 1'b1});
        #2 rst_n_i = 1'b0;
        #1 chk("async_rst_outs", {pll_en_o, pll_pdiv_o, pll_tim_o, pll_usb_o, lock_o, busy_o, irq_o},
               {1'b0, 4'd4, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
        rd(FRQ, rdv); chk("async_rst_frq", rdv, 8'h04);
        @(posedge clk_i); #1 rst_n_i = 1'b1;

        // lock interrupt: ack coinciding with the lock edge loses, next ack clears
        wr(CSR, 8'h02);
        idle(15);
        chk("irq_before_lock", {lock_o, irq_o}, 2'b00);
        irq_ack_i = 1'b1;
        idle(1);
        chk("irq_at_lock", {lock_o, irq_o}, {1'b1, exp_irq});
        idle(1);
        chk("irq_after_ack", {lock_o, irq_o}, 2'b10);
        irq_ack_i = 1'b0;

        // random traffic against the model
        @(posedge clk_i); #1 rst_n_i = 1'b0;
        #2 rst_n_i = 1'b1;
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            rw = ($urandom_range(0, 99) < 4);
            case ($urandom_range(0, 9))
                0, 1, 2: ra = CSR;
                9:       ra = 16'($urandom_range(0, 255));
                default: ra = FRQ;
            endcase
            rdat = 8'($urandom);
            if (ra == CSR) rdat[1] = ($urandom_range(0, 3) != 0);
            if (ra == FRQ) begin
                case ($urandom_range(0, 3))
                    0:       rdat[3:0] = 4'd3;
                    1:       rdat[3:0] = 4'd4;
                    2:       rdat[3:0] = 4'd10;
                    default: rdat[3:0] = 4'($urandom);
                endcase
            end
            wr_i = rw; addr_i = ra; bus_i = rdat;
            rd_i = 1'($urandom_range(0, 1));
            irq_ack_i = ($urandom_range(0, 4) == 0);
            #1 chk($sformatf("rand%0d_bus", c), bus_o, rd_i ? m_read(ra) : 8'h00);
            m_edge(rw, ra, rdat, irq_ack_i);
            @(posedge clk_i); #1;
            chk($sformatf("rand%0d_outs", c),
                {pll_en_o, pll_pdiv_o, pll_tim_o, pll_usb_o, lock_o, busy_o, irq_o}, m_outs());
        end
        wr_i = 1'b0; rd_i = 1'b0; irq_ack_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/atmega_pll_ctrl.md
# atmega_pll_ctrl

PLL enable/lock sequencer and clock-switch controller for the ATmega PLL. Owns the PLLCSR/PLLFRQ I/O registers on the CPU data bus, emulates the PLL lock time with a counter, and presents the PLL clock generator with stable, sequenced control (enable, PDIV code, timer/USB source select). Timer clock source only leaves the system clock while the PLL is reported locked, and every source change passes through a system-clock gap.

## Interface
- BUS_ADDR_DATA_LEN, 16, I/O address width
- PLLCSR_ADDR, 'h49, PLLCSR address
- PLLFRQ_ADDR, 'h52, PLLFRQ address
- LOCK_CYCLES, 16, emulated lock time in clk_i cycles (2..255)
- clk_i  in  1  system clock; sole clock of the block
- rst_n_i  in  1  reset, asynchronous assert, active-low
- addr_i  in  BUS_ADDR_DATA_LEN  I/O address
- wr_i  in  1  write strobe, one cycle per write
- rd_i  in  1  read strobe
- bus_i  in  8  write data
- bus_o  out  8  read data, combinational; 0 when rd_i low or address unmatched
- pll_en_o  out  1  enable to PLL clock generator
- pll_pdiv_o  out  4  applied PDIV code
- pll_tim_o  out  2  applied PLLTM select (00 = system clock)
- pll_usb_o  out  1  applied PLLUSB (divide-by-2)
- lock_o  out  1  PLOCK mirror
- busy_o  out  1  high in LOCKING or GAP
- irq_o  out  1  lock interrupt (see Configuration)
- irq_ack_i  in  1  interrupt acknowledge

## Operation
- Registers: PLLCSR = {3'b0, PINDIV, 2'b0, PLLE, PLOCK}; PLOCK read-only, writes to bits 7:5, 3:2, 0 ignored. PLLFRQ = {PINMUX, PLLUSB, PLLTM[1:0], PDIV[3:0]}, fully R/W.
- Valid PDIV codes: 3,4,5,7,8,9,10. Invalid codes are stored and read back but never applied; pll_pdiv_o keeps last valid code, no relock.
- States: OFF, LOCKING, LOCKED, GAP.
- OFF: pll_en_o=0, lock_o=0, pll_tim_o=00. PLLCSR write with PLLE=1 -> LOCKING; load counter LOCK_CYCLES-1; apply PDIV if valid.
- LOCKING: pll_en_o=1, pll_tim_o=00; counter decrements each cycle; at counter==0 -> LOCKED, PLOCK=1.
- LOCKED: pll_tim_o=PLLTM, pll_usb_o=PLLUSB.
- PLLFRQ write with valid PDIV differing from pll_pdiv_o in LOCKING or LOCKED: PLOCK cleared, pll_tim_o=00, new PDIV applied, counter reloaded, -> LOCKING (restart).
- PLLFRQ write in LOCKED changing PLLTM (PDIV unchanged): pll_tim_o=00, -> GAP for 2 cycles, then LOCKED with new PLLTM. PLLTM writes during GAP restart the 2-cycle gap.
- PLLCSR write with PLLE=0 in any state -> OFF; counter cleared, PLOCK=0. PLLE=1 rewrite while LOCKING/LOCKED/GAP: no effect.
- pll_usb_o updates on any PLLFRQ write, independent of state.

## Timing
- Reset (rst_n_i low, async): PLLCSR=0x00, PLLFRQ=0x04, state OFF, pll_en_o=0, pll_pdiv_o=4'b0100, pll_tim_o=00, pll_usb_o=0, lock_o=0, busy_o=0, irq_o=0. Reset mid-LOCKING aborts immediately.
- All outputs except bus_o registered. Write sampled at edge N: register and outputs change after edge N.
- PLLE=1 at edge N: pll_en_o=1 after N; lock_o=1 and pll_tim_o=PLLTM after edge N+LOCK_CYCLES.
- Read returns updated register value the cycle after the write edge.

## Configuration
- ATMEGA_PLL_CTRL_LOCK_IRQ_EN defined: irq_o sets on the LOCKING->LOCKED edge, holds until irq_ack_i high at an edge; set wins over simultaneous ack.
- Undefined: irq_o tied 0, irq_ack_i ignored, no flop.

## Test plan
- Reset then read PLLCSR/PLLFRQ -> 0x00/0x04; pll_pdiv_o=4, pll_tim_o=00.
- PLLFRQ<=0x1A, PLLCSR<=0x02 at edge N (LOCK_CYCLES=16) -> pll_en_o=1 after N, PLLCSR reads 0x02 until N+16, then 0x03, pll_tim_o=01, pll_pdiv_o=10.
- Locked, PLLFRQ<=0x13 -> lock_o=0 and pll_tim_o=00 next cycle, relock 16 cycles later with pll_pdiv_o=3; then PLLFRQ<=0x06 (invalid) -> pll_pdiv_o stays 3, lock_o stays 1.
- Locked with PLLTM=01, PLLFRQ<=0x34 -> pll_tim_o=00 for exactly 2 cycles, then 11; busy_o high during gap.
- PLLCSR<=0x00 at counter=5 in LOCKING -> OFF next cycle; rst_n_i pulsed mid-LOCKING -> all outputs to reset values asynchronously.
- With ATMEGA_PLL_CTRL_LOCK_IRQ_EN: irq_o rises with lock_o; irq_ack_i on lock edge keeps irq_o=1; ack one cycle later clears it.
